// File: rtl/ram_rd_frontend_pkg.sv
// Shared constants and helpers for the RAM read frontend and its response FIFO.
package ram_rd_frontend_pkg;

  localparam int unsigned RSP_DEPTH_MIN = 2;
  localparam int unsigned RSP_DEPTH_MAX = 16;

  // Circular pointer increment for arbitrary (non power-of-2) depths.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/ram_rsp_fifo.sv
// Response queue: circular buffer of DEPTH entries, head exposed combinationally.
// Storage is not reset; only pointers and count are.
module ram_rsp_fifo
  import ram_rd_frontend_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Next-state for pointers and occupancy; push+pop together leaves count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = PW'(wrap_inc(32'(wr_ptr_q), DEPTH));
    if (pop)  rd_ptr_d = PW'(wrap_inc(32'(rd_ptr_q), DEPTH));
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Data storage write; intentionally left unreset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head = mem_q[rd_ptr_q];
  assign cnt  = cnt_q;

endmodule

// File: rtl/ram_rd_frontend.sv
// Read frontend for a 1-cycle-latency RAM: credit-based acceptance so that every
// issued read has a reserved FIFO slot, write-hazard stall, in-order responses.
module ram_rd_frontend
  import ram_rd_frontend_pkg::*;
#(
  parameter int unsigned RAM_ADDR_WIDTH = 8,
  parameter int unsigned RAM_DATA_WIDTH = 32,
  parameter int unsigned RSP_DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_val,
  output logic                      req_rdy,
  input  logic [RAM_ADDR_WIDTH-1:0] req_addr,
  output logic                      rsp_val,
  input  logic                      rsp_rdy,
  output logic [RAM_DATA_WIDTH-1:0] rsp_data,
  output logic                      ram_r_val,
  output logic [RAM_ADDR_WIDTH-1:0] ram_r_addr,
  input  logic [RAM_DATA_WIDTH-1:0] ram_r_data,
  input  logic                      wr_val,
  input  logic [RAM_ADDR_WIDTH-1:0] wr_addr
);

  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

  logic          hazard;
  logic          credit_ok;
  logic          inflight_q, inflight_d;
  logic          push, pop;
  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   occupancy;

  // Acceptance: credit counts queued plus in-flight reads, never rsp_rdy, so
  // req_rdy has no combinational path from the consumer side.
  always_comb begin
    hazard     = wr_val && (wr_addr == req_addr);
    occupancy  = {1'b0, fifo_cnt} + (CW+1)'(inflight_q);
    credit_ok  = occupancy < (CW+1)'(RSP_DEPTH);
    req_rdy    = credit_ok && !hazard && rst_n;
    ram_r_val  = req_val && req_rdy;
    ram_r_addr = req_addr;
    inflight_d = ram_r_val;
    push       = inflight_q && rst_n;
    rsp_val    = (fifo_cnt != '0) && rst_n;
    pop        = rsp_val && rsp_rdy;
  end

  // In-flight marker: RAM data is valid exactly one cycle after issue.
  always_ff @(posedge clk) begin
    if (!rst_n) inflight_q <= 1'b0;
    else        inflight_q <= inflight_d;
  end

  ram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (RAM_DATA_WIDTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (ram_r_data),
    .pop       (pop),
    .head      (rsp_data),
    .cnt       (fifo_cnt)
  );

`ifdef RAM_CHECKER
  // Occupancy bound and no pop from an empty queue.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (occupancy <= (CW+1)'(RSP_DEPTH));
      assert (!(pop && (fifo_cnt == '0)));
    end
  end
`endif

endmodule

// File: tb/tb_ram_rd_frontend.sv
// Bench for ram_rd_frontend: instance 0 uses RSP_DEPTH=4, instance 1 RSP_DEPTH=3.
module tb_ram_rd_frontend;

  logic        clk = 1'b0;
  logic        rst_n      [2];
  logic        req_val    [2];
  logic        req_rdy    [2];
  logic [7:0]  req_addr   [2];
  logic        rsp_val    [2];
  logic        rsp_rdy    [2];
  logic [31:0] rsp_data   [2];
  logic        ram_r_val  [2];
  logic [7:0]  ram_r_addr [2];
  logic [31:0] ram_r_data [2];
  logic        wr_val     [2];
  logic [7:0]  wr_addr    [2];
  logic [31:0] wr_data;
  logic [31:0] mem [256];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ram_rd_frontend #(
      .RAM_ADDR_WIDTH (8),
      .RAM_DATA_WIDTH (32),
      .RSP_DEPTH      ((g == 0) ? 4 : 3)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n[g]),
      .req_val    (req_val[g]),
      .req_rdy    (req_rdy[g]),
      .req_addr   (req_addr[g]),
      .rsp_val    (rsp_val[g]),
      .rsp_rdy    (rsp_rdy[g]),
      .rsp_data   (rsp_data[g]),
      .ram_r_val  (ram_r_val[g]),
      .ram_r_addr (ram_r_addr[g]),
      .ram_r_data (ram_r_data[g]),
      .wr_val     (wr_val[g]),
      .wr_addr    (wr_addr[g])
    );
  end

  // RAM model: 1-cycle read latency, garbage when no read was issued.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      ram_r_data[k] <= ram_r_val[k] ? mem[ram_r_addr[k]] : 32'hBAD0BAD0;
    if (wr_val[0]) mem[wr_addr[0]] <= wr_data;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rv;
    logic [7:0]  ra;
    logic        rr;
    logic        wv;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic        e_rdy;
    logic        e_rrv;
    logic        e_val;
    logic        chk_d;
    logic [31:0] e_data;
  } vec_t;

  function automatic vec_t mk(input logic rst, rv, input logic [7:0] ra, input logic rr, wv,
                              input logic [7:0] wa, input logic [31:0] wd,
                              input logic e_rdy, e_rrv, e_val, chk_d, input logic [31:0] e_data);
    vec_t v;
    v.rst = rst; v.rv = rv; v.ra = ra; v.rr = rr; v.wv = wv; v.wa = wa; v.wd = wd;
    v.e_rdy = e_rdy; v.e_rrv = e_rrv; v.e_val = e_val; v.chk_d = chk_d; v.e_data = e_data;
    return v;
  endfunction

  task automatic idle(input int k);
    req_val[k] = 1'b0; req_addr[k] = 8'h00; rsp_rdy[k] = 1'b1; wr_val[k] = 1'b0; wr_addr[k] = 8'h00;
  endtask

  task automatic reset_dut(input int k);
    @(negedge clk); idle(k); rst_n[k] = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n[k] = 1'b1;
  endtask

  // Streams n requests at base.. and scoreboards responses.
  // mode 0: rsp_rdy=1, 1: random, 2: rsp_rdy=0 for 'hold' cycles then 1.
  task automatic run_stream(input int k, input int n, input logic [7:0] base, input int mode,
                            input int hold, input bit strict, input int max_cyc,
                            output int first_c, output int last_c,
                            output int acc_hold, output logic rdy_hold);
    logic [31:0] q[$];
    int sent = 0, recv = 0, c = 0;
    first_c = -1; last_c = -1; acc_hold = -1; rdy_hold = 1'bx;
    // First cycle starts on the negedge right after reset release (already there).
    while (recv < n && c < max_cyc) begin
      if (c != 0) @(negedge clk);
      req_val[k]  = (sent < n);
      req_addr[k] = base + 8'(sent);
      case (mode)
        0:       rsp_rdy[k] = 1'b1;
        1:       rsp_rdy[k] = 1'($urandom_range(0, 1));
        default: rsp_rdy[k] = (c >= hold);
      endcase
      #1;
      if (mode == 2 && c == hold - 1) begin acc_hold = sent; rdy_hold = req_rdy[k]; end
      if (strict && req_val[k]) chk($sformatf("s%0d_rdy_c%0d", k, c), 32'(req_rdy[k]), 32'd1);
      if (rsp_val[k] && rsp_rdy[k]) begin
        if (q.size() == 0) chk($sformatf("s%0d_spurious_c%0d", k, c), 32'(rsp_val[k]), 32'd0);
        else chk($sformatf("s%0d_rsp%0d", k, recv), rsp_data[k], q.pop_front());
        if (first_c < 0) first_c = c;
        last_c = c;
        recv++;
      end
      if (req_val[k] && req_rdy[k]) begin q.push_back(mem[req_addr[k]]); sent++; end
      c++;
    end
    chk($sformatf("s%0d_count", k), 32'(recv), 32'(n));
    @(negedge clk); idle(k);
  endtask

  vec_t tbl[18];
  int   fc, lc, ah;
  logic rh;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h5A5A0000 | 32'(i);
    mem[8'h10] = 32'hDEADBEEF;
    wr_data = 32'h0;
    for (int k = 0; k < 2; k++) begin rst_n[k] = 1'b0; idle(k); end

    //            rst rv ra     rr wv wa     wd            rdy rrv val cd data
    tbl[0]  = mk(0, 1, 8'h10, 1, 0, 8'h00, 32'h0,        0, 0, 0, 0, 32'h0);
    tbl[1]  = mk(0, 1, 8'h10, 1, 0, 8'h00, 32'h0,        0, 0, 0, 0, 32'h0);
    tbl[2]  = mk(1, 1, 8'h10, 1, 0, 8'h00, 32'h0,        1, 1, 0, 0, 32'h0);
    tbl[3]  = mk(1, 0, 8'h10, 1, 0, 8'h00, 32'h0,        1, 0, 0, 0, 32'h0);
    tbl[4]  = mk(1, 0, 8'h00, 1, 0, 8'h00, 32'h0,        1, 0, 1, 1, 32'hDEADBEEF);
    tbl[5]  = mk(1, 0, 8'h00, 1, 0, 8'h00, 32'h0,        1, 0, 0, 0, 32'h0);
    tbl[6]  = mk(1, 1, 8'h20, 1, 1, 8'h20, 32'hCAFEF00D, 0, 0, 0, 0, 32'h0);
    tbl[7]  = mk(1, 1, 8'h20, 1, 1, 8'h20, 32'h12345678, 0, 0, 0, 0, 32'h0);
    tbl[8]  = mk(1, 1, 8'h20, 1, 0, 8'h00, 32'h0,        1, 1, 0, 0, 32'h0);
    tbl[9]  = mk(1, 0, 8'h00, 1, 0, 8'h00, 32'h0,        1, 0, 0, 0, 32'h0);
    tbl[10] = mk(1, 0, 8'h00, 0, 0, 8'h00, 32'h0,        1, 0, 1, 1, 32'h12345678);
    tbl[11] = mk(1, 1, 8'h10, 0, 1, 8'h21, 32'h0,        1, 1, 1, 1, 32'h12345678);
    tbl[12] = mk(1, 1, 8'h30, 0, 1, 8'h30, 32'h0,        0, 0, 1, 1, 32'h12345678);
    tbl[13] = mk(1, 1, 8'h31, 0, 1, 8'h30, 32'h0,        1, 1, 1, 1, 32'h12345678);
    tbl[14] = mk(1, 0, 8'h00, 1, 0, 8'h00, 32'h0,        1, 0, 1, 1, 32'h12345678);
    tbl[15] = mk(1, 0, 8'h00, 1, 0, 8'h00, 32'h0,        1, 0, 1, 1, 32'hDEADBEEF);
    tbl[16] = mk(1, 0, 8'h00, 1, 0, 8'h00, 32'h0,        1, 0, 1, 1, 32'h5A5A0031);
    tbl[17] = mk(1, 0, 8'h00, 1, 0, 8'h00, 32'h0,        1, 0, 0, 0, 32'h0);

    // Table: reset, single read, hazard stall/release, backpressure, addr change under stall.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      rst_n[0] = tbl[i].rst; req_val[0] = tbl[i].rv; req_addr[0] = tbl[i].ra;
      rsp_rdy[0] = tbl[i].rr; wr_val[0] = tbl[i].wv; wr_addr[0] = tbl[i].wa; wr_data = tbl[i].wd;
      #1;
      chk($sformatf("v%0d_req_rdy", i), 32'(req_rdy[0]), 32'(tbl[i].e_rdy));
      chk($sformatf("v%0d_ram_r_val", i), 32'(ram_r_val[0]), 32'(tbl[i].e_rrv));
      chk($sformatf("v%0d_ram_r_addr", i), 32'(ram_r_addr[0]), 32'(tbl[i].ra));
      chk($sformatf("v%0d_rsp_val", i), 32'(rsp_val[0]), 32'(tbl[i].e_val));
      if (tbl[i].chk_d) chk($sformatf("v%0d_rsp_data", i), rsp_data[0], tbl[i].e_data);
    end
    @(negedge clk); idle(0);

    // Back-to-back: 8 requests, full throughput, 2-cycle latency, consecutive responses.
    reset_dut(0);
    run_stream(0, 8, 8'h00, 0, 0, 1'b1, 40, fc, lc, ah, rh);
    chk("b2b_first_rsp_cycle", 32'(fc), 32'd2);
    chk("b2b_rsp_span", 32'(lc - fc), 32'd7);

    // Backpressure: 6 requests, consumer stalled 8 cycles.
    reset_dut(0);
    run_stream(0, 6, 8'h40, 2, 8, 1'b0, 60, fc, lc, ah, rh);
    chk("bp_accepted_while_stalled", 32'(ah), 32'd4);
    chk("bp_req_rdy_when_full", 32'(rh), 32'd0);
    chk("bp_first_rsp_cycle", 32'(fc), 32'd8);

    // Reset mid-flight: 3 queued + 1 in flight, then 1 cycle of reset.
    reset_dut(0);
    for (int c = 0; c < 4; c++) begin
      if (c != 0) @(negedge clk);
      req_val[0] = 1'b1; req_addr[0] = 8'h50 + 8'(c); rsp_rdy[0] = 1'b0;
      #1 chk($sformatf("rst_acc%0d", c), 32'(req_rdy[0]), 32'd1);
    end
    @(negedge clk);
    rst_n[0] = 1'b0; req_addr[0] = 8'h60;
    #1;
    chk("rst_req_rdy", 32'(req_rdy[0]), 32'd0);
    chk("rst_ram_r_val", 32'(ram_r_val[0]), 32'd0);
    chk("rst_rsp_val", 32'(rsp_val[0]), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rst_n[0] = 1'b1; req_val[0] = 1'b0; rsp_rdy[0] = 1'b1;
      #1 chk($sformatf("post_rst_rsp_val%0d", c), 32'(rsp_val[0]), 32'd0);
    end
    @(negedge clk);
    req_val[0] = 1'b1; req_addr[0] = 8'h61;
    #1 chk("post_rst_acc", 32'(ram_r_val[0]), 32'd1);
    @(negedge clk);
    req_val[0] = 1'b0;
    #1 chk("post_rst_lat1", 32'(rsp_val[0]), 32'd0);
    @(negedge clk);
    #1;
    chk("post_rst_lat2", 32'(rsp_val[0]), 32'd1);
    chk("post_rst_data", rsp_data[0], 32'h5A5A0061);
    @(negedge clk);
    #1 chk("post_rst_drain", 32'(rsp_val[0]), 32'd0);
    idle(0);

    // Wrap: RSP_DEPTH=3, 10 requests, random consumer readiness.
    reset_dut(1);
    run_stream(1, 10, 8'h80, 1, 0, 1'b0, 300, fc, lc, ah, rh);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_rd_frontend.md
RAM_RD_FRONTEND -- requirements
Module: ram_rd_frontend

Interface
REQ-001 Parameter RAM_ADDR_WIDTH, default 8, SHALL set the width of the RAM address in bits.
REQ-002 Parameter RAM_DATA_WIDTH, default 32, SHALL set the width of the RAM data in bits.
REQ-003 Parameter RSP_DEPTH, default 4, SHALL set the number of response FIFO entries; legal values are 2..16.
REQ-004 The block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-005 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_val  in  1  read request valid.
- req_rdy  out  1  request accepted when req_val and req_rdy are both 1.
- req_addr  in  RAM_ADDR_WIDTH  read address.
- rsp_val  out  1  response valid.
- rsp_rdy  in  1  response consumer ready.
- rsp_data  out  RAM_DATA_WIDTH  response data.
- ram_r_val  out  1  RAM read-port valid.
- ram_r_addr  out  RAM_ADDR_WIDTH  RAM read-port address.
- ram_r_data  in  RAM_DATA_WIDTH  RAM read data, valid exactly 1 cycle after ram_r_val.
- wr_val  in  1  snooped RAM write valid (any write port, pre-ORed).
- wr_addr  in  RAM_ADDR_WIDTH  snooped RAM write address.

Function
REQ-006 hazard SHALL equal wr_val AND (wr_addr == req_addr).
REQ-007 req_rdy SHALL equal (fifo_cnt + inflight_f < RSP_DEPTH) AND NOT hazard AND rst_n.
REQ-008 req_rdy SHALL have no combinational path from rsp_rdy.
REQ-009 ram_r_val SHALL equal req_val AND req_rdy, in the same cycle (combinational).
REQ-010 ram_r_addr SHALL equal req_addr.
REQ-011 inflight_f SHALL be a register loaded with ram_r_val each cycle.
REQ-012 When inflight_f is 1, ram_r_data SHALL be pushed into the FIFO in that cycle, and the push SHALL never be dropped.
REQ-013 rsp_val SHALL equal (fifo_cnt != 0).
REQ-014 rsp_data SHALL be the FIFO head; the FIFO SHALL pop when rsp_val AND rsp_rdy are both 1.
REQ-015 A push and a pop in the same cycle SHALL leave fifo_cnt unchanged, including when the FIFO is full and when it is empty.
REQ-016 A simultaneous push and pop on an empty FIFO SHALL NOT occur, because rsp_val is 0 when the FIFO is empty.
REQ-017 Responses SHALL be returned in request order.
REQ-018 Minimum request-to-rsp_val latency SHALL be 2 cycles: accept in cycle N, capture at the end of N+1, rsp_val in N+2.
REQ-019 With RSP_DEPTH >= 3 and rsp_rdy held at 1, the block SHALL accept 1 request per cycle.
REQ-020 Read and write pointers SHALL wrap from RSP_DEPTH-1 to 0; the design SHALL support non-power-of-2 depths.
REQ-021 fifo_cnt SHALL be $clog2(RSP_DEPTH+1) bits wide.
REQ-022 fifo_cnt + inflight_f SHALL never exceed RSP_DEPTH (full/overflow bound).
REQ-023 Under a persistent write hazard, req_rdy SHALL stay 0 and the request SHALL wait with no timeout.
REQ-024 A change of req_addr while req_val=1 and req_rdy=0 SHALL be legal and SHALL NOT be flagged.

Reset
REQ-025 While rst_n=0: fifo_cnt=0, read/write pointers=0, inflight_f=0, rsp_val=0, req_rdy=0, ram_r_val=0.
REQ-026 FIFO data storage SHALL NOT be reset.
REQ-027 Reset mid-operation SHALL discard all in-flight and queued responses, and RAM data returning in the cycle after reset SHALL be ignored.
REQ-028 Requests SHALL be accepted from the first cycle in which rst_n=1.

Structure
REQ-029 No shared package is required; all widths SHALL derive from parameters.
REQ-030 The response queue SHALL be one sub-module, ram_rsp_fifo (parameters depth and width; push/pop/cnt/head interface).
REQ-031 Hazard, credit and inflight logic SHALL reside in the top module.
REQ-032 Under RAM_CHECKER, the block SHALL add an overflow assertion on REQ-022 and a check that pop never occurs when the FIFO is empty.

Verification
REQ-033 Single read: preload addr 0x10=0xDEADBEEF, req addr 0x10 in cycle 0 -> ram_r_val=1 in cycle 0; rsp_val=1 with rsp_data 0xDEADBEEF in cycle 2.
REQ-034 Back-to-back: 8 requests to addrs 0..7 with rsp_rdy=1 and RSP_DEPTH=4 -> req_rdy stays 1; 8 in-order responses on consecutive cycles.
REQ-035 Backpressure: rsp_rdy=0 and 6 requests, RSP_DEPTH=4 -> exactly 4 accepted, req_rdy=0 thereafter; rsp_rdy=1 -> 4 in-order responses, then the remaining 2 are accepted.
REQ-036 Hazard: wr_val=1, wr_addr=0x20, req addr 0x20 -> req_rdy=0 and ram_r_val=0; when wr_val drops -> accepted, and the response returns the newly written data.
REQ-037 Reset mid-flight: 3 queued plus 1 inflight, then rst_n=0 for 1 cycle -> rsp_val=0 and fifo_cnt=0 afterward, with no stale response.
REQ-038 Wrap: RSP_DEPTH=3, 10 requests with random rsp_rdy -> all 10 responses in order, and the pointer wraps at least 3 times.
